// File: rtl/fft_pkg.sv
// Shared types and default sizes for the FFT front-end sequencer.
package fft_pkg;

  localparam int unsigned FFT_N          = 512;
  localparam int unsigned BLK_SIZE_DEF   = 16;
  localparam int unsigned FRAME_BLKS_DEF = FFT_N / BLK_SIZE_DEF;
  localparam int unsigned SAMPLE_W_DEF   = 9;

  typedef logic signed [SAMPLE_W_DEF-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN
  } seq_state_t;

endpackage

// File: rtl/fft_out_tracker.sv
// Counts result blocks from the last FFT stage, tags frame boundaries and
// tracks how many input frames are still awaiting their results.
module fft_out_tracker
  import fft_pkg::*;
#(
  parameter int unsigned FRAME_BLKS = FRAME_BLKS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       p_valid,
  input  logic       frame_start,
  output logic       out_sof,
  output logic       out_eof,
  output logic       frame_done,
  output logic [1:0] outstanding
);

  localparam int unsigned CW = $clog2(FRAME_BLKS);

  logic [CW-1:0] out_cnt;

  assign out_sof = p_valid & (out_cnt == '0);
  assign out_eof = p_valid & (out_cnt == CW'(FRAME_BLKS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt     <= '0;
      frame_done  <= 1'b0;
      outstanding <= '0;
    end else if (flush) begin
      out_cnt     <= '0;
      frame_done  <= 1'b0;
      outstanding <= '0;
    end else begin
      frame_done <= out_eof;
      if (p_valid) out_cnt <= out_eof ? '0 : out_cnt + CW'(1);
      // Start and completion in the same cycle cancel; saturate at 3, never underflow.
      if (frame_start && !out_eof && outstanding != 2'd3)
        outstanding <= outstanding + 2'd1;
      else if (!frame_start && out_eof && outstanding != 2'd0)
        outstanding <= outstanding - 2'd1;
    end
  end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Front-end sequencer: groups upstream blocks into frames, enforces a drain gap
// per frame and tracks returning result blocks. Optional stats: FFT_SEQ_STATS_EN.
module fft_frame_sequencer
  import fft_pkg::*;
#(
  parameter int unsigned IN_WIDTH     = $bits(sample_t),
  parameter int unsigned BLK_SIZE     = BLK_SIZE_DEF,
  parameter int unsigned FRAME_BLKS   = FRAME_BLKS_DEF,
  parameter int unsigned DRAIN_CYCLES = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      flush,
  input  logic                                      s_valid,
  output logic                                      s_ready,
  input  logic signed [BLK_SIZE-1:0][IN_WIDTH-1:0]  s_i,
  input  logic signed [BLK_SIZE-1:0][IN_WIDTH-1:0]  s_q,
  output logic                                      m_valid,
  output logic signed [BLK_SIZE-1:0][IN_WIDTH-1:0]  m_i,
  output logic signed [BLK_SIZE-1:0][IN_WIDTH-1:0]  m_q,
  output logic [$clog2(FRAME_BLKS)-1:0]             m_blk_idx,
  input  logic                                      p_valid,
  output logic                                      out_sof,
  output logic                                      out_eof,
  output logic                                      frame_done,
  output logic                                      busy
`ifdef FFT_SEQ_STATS_EN
  ,
  output logic [15:0]                               frame_cnt,
  output logic [15:0]                               gap_cnt
`endif
);

  localparam int unsigned CW = $clog2(FRAME_BLKS);
  localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1);

  seq_state_t    state;
  logic [CW-1:0] blk_cnt;
  logic [DW-1:0] drain_cnt;
  logic          accept;
  logic          frame_start;
  logic [1:0]    outstanding;

  assign accept      = s_valid & s_ready & ~flush;
  assign frame_start = accept & (state == IDLE);
  assign busy        = (state != IDLE) | (outstanding != 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      blk_cnt   <= '0;
      drain_cnt <= '0;
      s_ready   <= 1'b0;
      m_valid   <= 1'b0;
      m_i       <= '0;
      m_q       <= '0;
      m_blk_idx <= '0;
    end else if (flush) begin
      state     <= IDLE;
      blk_cnt   <= '0;
      drain_cnt <= '0;
      s_ready   <= 1'b1;
      m_valid   <= 1'b0;
    end else begin
      m_valid <= accept;
      if (accept) begin
        m_i       <= s_i;
        m_q       <= s_q;
        m_blk_idx <= blk_cnt;
      end
      unique case (state)
        IDLE: begin
          s_ready <= 1'b1;
          if (accept) begin
            blk_cnt <= CW'(1);
            state   <= FEED;
          end
        end
        FEED: begin
          if (accept) begin
            if (blk_cnt == CW'(FRAME_BLKS - 1)) begin
              blk_cnt   <= '0;
              drain_cnt <= DW'(DRAIN_CYCLES - 1);
              s_ready   <= 1'b0;
              state     <= DRAIN;
            end else begin
              blk_cnt <= blk_cnt + CW'(1);
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            s_ready <= 1'b1;
            state   <= IDLE;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  fft_out_tracker #(
    .FRAME_BLKS(FRAME_BLKS)
  ) u_out_tracker (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .p_valid    (p_valid),
    .frame_start(frame_start),
    .out_sof    (out_sof),
    .out_eof    (out_eof),
    .frame_done (frame_done),
    .outstanding(outstanding)
  );

`ifdef FFT_SEQ_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      gap_cnt   <= '0;
    end else if (flush) begin
      frame_cnt <= '0;
      gap_cnt   <= '0;
    end else begin
      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
      if (state == FEED && !s_valid && gap_cnt != '1) gap_cnt <= gap_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Self-checking bench for fft_frame_sequencer: abstract per-cycle model plus
// directed scenarios with literal expectations.
module tb_fft_frame_sequencer;

  localparam int BS = 16;
  localparam int IW = 9;
  localparam int FB = 32;
  localparam int DC = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic s_valid = 1'b0;
  logic p_valid = 1'b0;
  logic signed [BS-1:0][IW-1:0] s_i = '0;
  logic signed [BS-1:0][IW-1:0] s_q = '0;
  logic s_ready, m_valid, out_sof, out_eof, frame_done, busy;
  logic signed [BS-1:0][IW-1:0] m_i, m_q;
  logic [4:0] m_blk_idx;
`ifdef FFT_SEQ_STATS_EN
  logic [15:0] frame_cnt, gap_cnt;
`endif

  fft_frame_sequencer #(
    .IN_WIDTH(IW), .BLK_SIZE(BS), .FRAME_BLKS(FB), .DRAIN_CYCLES(DC)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_i(s_i), .s_q(s_q),
    .m_valid(m_valid), .m_i(m_i), .m_q(m_q), .m_blk_idx(m_blk_idx),
    .p_valid(p_valid), .out_sof(out_sof), .out_eof(out_eof),
    .frame_done(frame_done), .busy(busy)
`ifdef FFT_SEQ_STATS_EN
    , .frame_cnt(frame_cnt), .gap_cnt(gap_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic int clamp3(input int v);
    return (v < 0) ? 0 : (v > 3) ? 3 : v;
  endfunction

  // Abstract model: accepted-in-frame count, a lockout countdown, result beat count.
  int  md_acc, md_lock, md_outcnt, md_outst;
  bit  md_rdy_en, md_mv, md_fd;
  logic [4:0] md_idx;
  logic signed [BS-1:0][IW-1:0] md_mi, md_mq;
  logic md_ready, md_take, md_start, md_sof, md_eof, md_busy;

  assign md_ready = md_rdy_en && (md_lock == 0);
  assign md_take  = s_valid && md_ready && !flush;
  assign md_start = md_take && (md_acc == 0);
  assign md_sof   = p_valid && (md_outcnt == 0);
  assign md_eof   = p_valid && (md_outcnt == FB - 1);
  assign md_busy  = (md_acc != 0) || (md_lock != 0) || (md_outst != 0);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      md_acc <= 0; md_lock <= 0; md_outcnt <= 0; md_outst <= 0;
      md_rdy_en <= 1'b0; md_mv <= 1'b0; md_fd <= 1'b0;
      md_idx <= '0; md_mi <= '0; md_mq <= '0;
    end else if (flush) begin
      md_acc <= 0; md_lock <= 0; md_outcnt <= 0; md_outst <= 0;
      md_rdy_en <= 1'b1; md_mv <= 1'b0; md_fd <= 1'b0;
    end else begin
      md_rdy_en <= 1'b1;
      md_mv     <= md_take;
      md_fd     <= md_eof;
      if (md_take) begin
        md_idx <= 5'(md_acc);
        md_mi  <= s_i;
        md_mq  <= s_q;
        if (md_acc == FB - 1) begin
          md_acc  <= 0;
          md_lock <= DC;
        end else begin
          md_acc <= md_acc + 1;
        end
      end else if (md_lock > 0) begin
        md_lock <= md_lock - 1;
      end
      if (p_valid) md_outcnt <= (md_outcnt + 1) % FB;
      md_outst <= clamp3(md_outst + int'(md_start) - int'(md_eof));
    end
  end

  always @(negedge clk) begin
    chk("s_ready", s_ready, md_ready);
    chk("m_valid", m_valid, md_mv);
    chk("m_blk_idx", m_blk_idx, md_idx);
    chk("m_i", m_i, md_mi);
    chk("m_q", m_q, md_mq);
    chk("out_sof", out_sof, md_sof);
    chk("out_eof", out_eof, md_eof);
    chk("frame_done", frame_done, md_fd);
    chk("busy", busy, md_busy);
  end

  // Observation of DUT activity for the directed literal checks.
  int cyc = 0;
  int n_mv = 0;
  int n_rdylo = 0;
  int q_first[$], q_sof[$], q_eof[$], q_fd[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    n_mv    <= n_mv + int'(m_valid);
    n_rdylo <= n_rdylo + int'(!s_ready);
    if (m_valid && m_blk_idx == 5'd0) q_first.push_back(cyc);
    if (out_sof) q_sof.push_back(cyc);
    if (out_eof) q_eof.push_back(cyc);
    if (frame_done) q_fd.push_back(cyc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int k);
    s_valid = 1'b1;
    for (int j = 0; j < BS; j++) begin
      s_i[j] = 9'(k);
      s_q[j] = 9'(j - k);
    end
    tick();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", busy, 0);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int s0, r0, b0, e0, f0;

    // Reset behaviour
    @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rdy_before_edge", s_ready, 0);
    tick();
    @(negedge clk);
    chk("rdy_after_edge", s_ready, 1);
    tick();

    // 32 contiguous beats, then the drain lockout
    s0 = n_mv; r0 = n_rdylo;
    for (int k = 0; k < FB; k++) beat(k);
    s_valid = 1'b0;
    repeat (40) tick();
    chk("t1_mv_cycles", n_mv - s0, 32);
    chk("t1_rdy_low", n_rdylo - r0, 16);

    // Back-to-back frames with s_valid held high
    b0 = q_first.size();
    for (int c = 0; c < 96; c++) beat(c);
    s_valid = 1'b0;
    repeat (20) tick();
    chk("t2_starts", q_first.size() - b0, 2);
    if (q_first.size() >= b0 + 2) chk("t2_period", q_first[b0+1] - q_first[b0], 48);

    do_flush();

    // Gap of 3 cycles after block 10
    s0 = n_mv; r0 = n_rdylo;
    for (int k = 0; k <= 10; k++) beat(k + 40);
    s_valid = 1'b0;
    repeat (3) tick();
    for (int k = 11; k < FB; k++) beat(k + 40);
    s_valid = 1'b0;
    repeat (20) tick();
    chk("t3_mv_cycles", n_mv - s0, 32);
    chk("t3_rdy_low", n_rdylo - r0, 16);
`ifdef FFT_SEQ_STATS_EN
    chk("t3_gap_cnt", gap_cnt, 3);
`endif

    do_flush();

    // 32 result beats with gaps; the last coincides with a new input frame start
    s0 = q_sof.size(); e0 = q_eof.size(); f0 = q_fd.size();
    for (int b = 0; b < FB - 1; b++) begin
      p_valid = 1'b1;
      tick();
      if (b % 5 == 2) begin
        p_valid = 1'b0;
        repeat (2) tick();
      end
    end
    p_valid = 1'b1;
    beat(0);
    p_valid = 1'b0;
    for (int k = 1; k < FB; k++) beat(k);
    s_valid = 1'b0;
    repeat (20) tick();
    chk("t4_sof_count", q_sof.size() - s0, 1);
    chk("t4_eof_count", q_eof.size() - e0, 1);
    chk("t4_fd_count", q_fd.size() - f0, 1);
    if (q_fd.size() > 0 && q_eof.size() > 0) chk("t4_fd_delay", q_fd[$] - q_eof[$], 1);
`ifdef FFT_SEQ_STATS_EN
    chk("t4_frame_cnt", frame_cnt, 1);
`endif

    // Flush on block 20 with s_valid high
    for (int k = 0; k < 20; k++) beat(k + 100);
    flush = 1'b1;
    beat(120);
    flush = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    chk("t5_m_valid", m_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_s_ready", s_ready, 1);
    beat(77);
    s_valid = 1'b0;
    @(negedge clk);
    chk("t5_idx_restart", m_blk_idx, 0);
    chk("t5_mv_restart", m_valid, 1);

    // Asynchronous reset mid-drain
    for (int k = 1; k < FB; k++) beat(k + 60);
    s_valid = 1'b0;
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_s_ready", s_ready, 0);
    chk("t6_idx", m_blk_idx, 0);
    chk("t6_m_i", m_i, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_rdy_before_edge", s_ready, 0);
    tick();
    @(negedge clk);
    chk("t6_rdy_after_edge", s_ready, 1);
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
